serial_add_ctrl: RTL and testbench

// - Sequences one 1-bit adder slice to add two WIDTH-bit operands bit-serially, LSB first.
// - Trades area for latency: one slice and WIDTH cycles replace a WIDTH-bit parallel adder.
// - Operands enter through a valid/ready input handshake; sum and carry leave through a valid/ready output handshake.
// - Sits between operand producers and consumers in area-constrained arithmetic paths.

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/serial_fa_slice.sv | 26 ++
 rtl/serial_add_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_e   : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   cnt_width : bit counter width, $clog2(width) but never less than 1
package serial_add_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // $clog2(1) is 0, which would give a zero-width counter for WIDTH=1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 32'd1) ? 32'd1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_fa_slice.sv
// Combinational 1-bit full adder built from two half-adder stages.
//   a_in, b_in : operand bits
//   c_in       : carry in
//   s_out      : sum bit
//   c_out      : carry out
module serial_fa_slice (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic s_out,
    output logic c_out
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    always_comb begin
        ha0_s = a_in ^ b_in;
        ha0_c = a_in & b_in;
        s_out = ha0_s ^ c_in;
        ha1_c = ha0_s & c_in;
        c_out = ha0_c | ha1_c;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice adds two WIDTH-bit operands LSB first.
//   clk_in, rst_n_in            : clock, synchronous active-low reset
//   a_in, b_in, cin_in          : operands and carry-in, captured on input handshake
//   in_valid_in / in_ready_out  : operand handshake
//   sum_out, carry_out          : result, stable while out_valid_out=1
//   out_valid_out / out_ready_in: result handshake
//   busy_out                    : high in RUN or DONE
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic             busy_out
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;

    logic slice_s;
    logic slice_c;

    serial_fa_slice u_slice (
        .a_in  (a_q[0]),
        .b_in  (b_q[0]),
        .c_in  (carry_q),
        .s_out (slice_s),
        .c_out (slice_c)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_in) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = cin_in;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Sum fills from the MSB so that after WIDTH shifts bit 0 is the LSB.
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = slice_s;
                carry_d          = slice_c;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                // Valid is registered: it rises one cycle after DONE is entered, giving
                // WIDTH+1 clocks from accept to out_valid.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready_in) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        in_ready_out  = (state_q == StIdle);
        busy_out      = (state_q != StIdle);
        out_valid_out = out_valid_q;
        sum_out       = sum_q;
        carry_out     = carry_q;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 instance driven through a scoreboard, plus a WIDTH=1
// instance for the single-bit corner.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] a, b, sum;
    logic       cin, in_valid, in_ready, carry, out_valid, out_ready, busy;

    logic [0:0] a1, b1, sum1;
    logic       cin1, in_valid1, in_ready1, carry1, out_valid1, out_ready1, busy1;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned n_acc  = 0;
    int unsigned n_out  = 0;

    logic [8:0] sb[$];
    logic [8:0] next_exp;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .a_in          (a),
        .b_in          (b),
        .cin_in        (cin),
        .in_valid_in   (in_valid),
        .in_ready_out  (in_ready),
        .sum_out       (sum),
        .carry_out     (carry),
        .out_valid_out (out_valid),
        .out_ready_in  (out_ready),
        .busy_out      (busy)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .a_in          (a1),
        .b_in          (b1),
        .cin_in        (cin1),
        .in_valid_in   (in_valid1),
        .in_ready_out  (in_ready1),
        .sum_out       (sum1),
        .carry_out     (carry1),
        .out_valid_out (out_valid1),
        .out_ready_in  (out_ready1),
        .busy_out      (busy1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge with inputs already driven; scores the upcoming posedge
    // and returns at the following negedge.
    task automatic tick();
        logic [8:0] exp_v;
        #1;
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                exp_v = sb.pop_front();
                check("result", 64'({carry, sum}), 64'(exp_v));
            end
        end
        if (rst_n && in_valid && in_ready) begin
            sb.push_back(next_exp);
            n_acc++;
        end
        @(negedge clk);
    endtask

    task automatic do_op(input logic [7:0] a_v, input logic [7:0] b_v, input logic c_v,
                         input logic [8:0] exp_v);
        int n;
        n = 0;
        in_valid = 1'b0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("op_ready_wait", 64'(in_ready), 64'd1);
        a        = a_v;
        b        = b_v;
        cin      = c_v;
        next_exp = exp_v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sb.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int lat;
        int n;
        int acc0;
        int out0;

        rst_n = 1'b0;
        a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
        next_exp = '0;
        repeat (3) @(negedge clk);

        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sum", 64'({carry, sum}), 64'd0);
        check("rst1_in_ready", 64'(in_ready1), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // 3C + 05: latency and result
        out_ready = 1'b1;
        do_op(8'h3C, 8'h05, 1'b0, 9'h041);
        check("run_busy", 64'(busy), 64'd1);
        check("run_in_ready", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("latency_w8", 64'(lat), 64'd9);
        drain();

        // carry ripple through all bits
        do_op(8'hFF, 8'h01, 1'b0, 9'h100);
        drain();
        do_op(8'hFF, 8'h00, 1'b1, 9'h100);
        drain();

        // backpressure in DONE; a pulse on in_valid in that window must be ignored
        out_ready = 1'b0;
        do_op(8'h12, 8'h34, 1'b0, 9'h046);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("bp_reach_done", 64'(out_valid), 64'd1);
        a = 8'hAA; b = 8'h55; cin = 1'b1; next_exp = 9'h1FF;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            tick();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_sum", 64'({carry, sum}), 64'h046);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        drain();
        out0 = n_out;
        repeat (15) tick();
        check("bp_no_extra", 64'(n_out - out0), 64'd0);
        check("bp_idle_valid", 64'(out_valid), 64'd0);

        // reset at RUN cycle 4 aborts the op
        do_op(8'h77, 8'h11, 1'b0, 9'h088);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_sum", 64'({carry, sum}), 64'd0);
        out0 = n_out;
        repeat (15) tick();
        check("abort_no_out", 64'(n_out - out0), 64'd0);
        do_op(8'h10, 8'h20, 1'b0, 9'h030);
        drain();

        // WIDTH=1 instance
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1; out_ready1 = 1'b0;
        check("w1_in_ready", 64'(in_ready1), 64'd1);
        @(negedge clk);
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency_w1", 64'(lat), 64'd2);
        check("w1_result", 64'({carry1, sum1}), 64'h3);
        out_ready1 = 1'b1;
        @(negedge clk);
        check("w1_after_valid", 64'(out_valid1), 64'd0);
        check("w1_after_ready", 64'(in_ready1), 64'd1);

        // random back-to-back traffic
        acc0 = n_acc;
        out0 = n_out;
        n = 0;
        while ((n_acc - acc0) < 1000 && n < 60000) begin
            a         = 8'($urandom);
            b         = 8'($urandom);
            cin       = 1'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            next_exp  = 9'(a) + 9'(b) + 9'(cin);
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("rand_accepts", 64'(n_acc - acc0), 64'd1000);
        drain();
        check("rand_outputs", 64'(n_out - out0), 64'(n_acc - acc0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
